reg8_resp_checker: RTL and testbench
====================================

// Module: reg8_resp_checker
// PURPOSE
//  Synthesizable response checker for the 8-bit register. It sits on the observe side of the
//  register: it samples the stimulus value (D) and the register output (Q) every cycle.
//  Each Q is checked against the D captured LATENCY cycles earlier, over a window of
//  NUM_SAMPLES compares. It reports pass/fail, match/error counts and the first mismatch.
// PARAMETERS
//  WIDTH        8    data width of D/Q
//  LATENCY      1    cycles from D capture to valid Q (>=1)
//  NUM_SAMPLES  256  compares per run (>=1); CW = $clog2(NUM_SAMPLES+1)
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      synchronous reset, active-low
//  start           in   1      run request; accepted only in IDLE or DONE
//  d_obs           in   WIDTH  value driven into register D
//  q_obs           in   WIDTH  register Q output
//  busy            out  1      1 in FILL or CHECK
//  done            out  1      1 in DONE (level, registered)
//  pass            out  1      done && err_count==0
//  match_count     out  CW     compares where q_obs==expected
//  err_count       out  CW     compares where q_obs!=expected
//  first_err_vld   out  1      a mismatch has been captured this run
//  first_err_idx   out  CW     sample index k of first mismatch
//  first_err_exp   out  WIDTH  expected value at first mismatch
//  first_err_got   out  WIDTH  q_obs at first mismatch
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; every output=0; delay line=0; all counters=0.
//  Reset has priority over all other events, including mid-FILL and mid-CHECK.
//  FSM: IDLE -start-> FILL (LATENCY>1) or CHECK (LATENCY==1).
//       FILL: stays for LATENCY-1 edges, then moves to CHECK.
//       CHECK: moves to DONE on the compare of sample NUM_SAMPLES-1.
//       DONE -start-> FILL/CHECK (same as from IDLE).
//  Start acceptance: E0 = edge at which start is accepted. At E0:
//   - clear counters and first_err_*;
//   - capture d_obs as sample 0 in the LATENCY-deep delay line.
//  start is ignored in FILL and CHECK; no restart and no counter clear.
//  Sample k = d_obs at edge E0+k. It is compared with q_obs at edge E0+k+LATENCY.
//  Compare edges: E0+LATENCY .. E0+LATENCY+NUM_SAMPLES-1, exactly NUM_SAMPLES of them.
//  Each compare edge increments either match_count or err_count, never both.
//  Counters cannot exceed NUM_SAMPLES; no wrap is possible.
//  First mismatch: on the first err increment of a run, set first_err_vld=1 and load
//  idx/exp/got. These hold until the next start acceptance or reset.
//  done rises at edge E0+LATENCY+NUM_SAMPLES-1, i.e. the final compare edge.
//  At that edge the counters already include the last compare.
//  Run length is LATENCY+NUM_SAMPLES cycles from start acceptance to done visible.
//  In DONE: all outputs hold; d_obs/q_obs are ignored.
//  Simultaneous start and rst_n=0: reset wins; state ends in IDLE.
//  X/Z on q_obs counts as a mismatch, using case inequality (!==).
// TESTING
//  1 Ideal reg (Q=D delayed 1), d_obs=k for k=0..255, start pulse ->
//    done after 257 cycles; match=256, err=0, pass=1, first_err_vld=0.
//  2 Same ramp, Q bit0 forced 1 only for sample 4 ->
//    err=1, match=255, pass=0, first_err idx=4, exp=8'h04, got=8'h05.
//  3 start pulsed again at sample 50 of a run ->
//    ignored; done still at cycle 257; counts are unchanged vs scenario 1.
//  4 rst_n=0 for one edge at sample 100 ->
//    next cycle: state IDLE, all outputs 0; a new start runs cleanly to pass=1.
//  5 LATENCY=2 build, reg plus extra flop, ramp 0..255 ->
//    busy for 258 cycles, then pass=1, match=256.
//  6 From DONE with err=3, start with ideal reg ->
//    counters and first_err_vld cleared at E0; final err=0, pass=1.

Source files
------------

// File: rtl/reg8_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : reg8_resp_checker
// Purpose  : Observe-side response checker for an 8-bit register. Every cycle
//            it samples the value driven into the register (d_obs) and the
//            register output (q_obs). Each q_obs is compared with the d_obs
//            captured LATENCY cycles earlier, across NUM_SAMPLES compares per
//            run. Reports pass/fail, match/error counts and the first mismatch.
// Ports    : clk            - rising-edge clock
//            rst_n          - synchronous reset, active-low
//            start          - run request, accepted only in IDLE or DONE
//            d_obs          - value driven into the register D input
//            q_obs          - register Q output
//            busy           - high while filling or checking
//            done           - registered level, high once the run has ended
//            pass           - done with zero errors
//            match_count    - compares where q_obs matched expected
//            err_count      - compares where q_obs differed from expected
//            first_err_vld  - a mismatch has been captured this run
//            first_err_idx  - sample index of the first mismatch
//            first_err_exp  - expected value at the first mismatch
//            first_err_got  - q_obs at the first mismatch
// Revision : 1.0 - initial release
// ============================================================================
module reg8_resp_checker #(
  parameter int WIDTH       = 8,
  parameter int LATENCY     = 1,
  parameter int NUM_SAMPLES = 256,
  localparam int CW         = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d_obs,
  input  logic [WIDTH-1:0] q_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    match_count,
  output logic [CW-1:0]    err_count,
  output logic             first_err_vld,
  output logic [CW-1:0]    first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);

  // Fill counter only needs to reach LATENCY-2; keep at least one bit.
  localparam int FW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CW-1:0] c_last_idx  = CW'(NUM_SAMPLES - 1);
  localparam logic [FW-1:0] c_fill_last = FW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_dl [LATENCY];
  logic [FW-1:0]    r_fill;
  logic [CW-1:0]    r_idx;
  logic [CW-1:0]    r_match;
  logic [CW-1:0]    r_err;
  logic             r_done;
  logic             r_fe_vld;
  logic [CW-1:0]    r_fe_idx;
  logic [WIDTH-1:0] r_fe_exp;
  logic [WIDTH-1:0] r_fe_got;

  logic             w_accept;
  logic             w_busy;
  logic             w_cmp;
  logic             w_mis;
  logic             w_shift;
  logic [WIDTH-1:0] w_exp;

  assign w_busy   = (r_state == S_FILL) || (r_state == S_CHECK);
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cmp    = (r_state == S_CHECK);
  // The delay line only moves while a run is being set up or is in flight,
  // so in DONE the captured history is frozen along with everything else.
  assign w_shift  = w_accept || w_busy;
  assign w_exp    = r_dl[LATENCY-1];
  // Case inequality so an X/Z on q_obs is scored as a mismatch in simulation.
  assign w_mis    = (q_obs !== w_exp);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_next = (LATENCY > 1) ? S_FILL : S_CHECK;
        end
      end
      S_FILL: begin
        // Sample 0 sits in stage 0 at E0; LATENCY-1 more shifts bring it to
        // the output stage, ready for the first compare.
        if (r_fill == c_fill_last) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_idx == c_last_idx) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Expected-value delay line, LATENCY stages deep
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dl
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_dl[0] <= '0;
          end else if (w_shift) begin
            r_dl[0] <= d_obs;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_dl[gi] <= '0;
          end else if (w_shift) begin
            r_dl[gi] <= r_dl[gi-1];
          end
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Counters, first-mismatch capture and done flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fill   <= '0;
      r_idx    <= '0;
      r_match  <= '0;
      r_err    <= '0;
      r_done   <= 1'b0;
      r_fe_vld <= 1'b0;
      r_fe_idx <= '0;
      r_fe_exp <= '0;
      r_fe_got <= '0;
    end else begin
      if (w_accept) begin
        r_fill   <= '0;
        r_idx    <= '0;
        r_match  <= '0;
        r_err    <= '0;
        r_fe_vld <= 1'b0;
        r_fe_idx <= '0;
        r_fe_exp <= '0;
        r_fe_got <= '0;
      end else begin
        if (r_state == S_FILL) begin
          r_fill <= r_fill + 1'b1;
        end
        if (w_cmp) begin
          // r_idx tops out at NUM_SAMPLES, which CW bits always hold.
          r_idx <= r_idx + 1'b1;
          if (w_mis) begin
            r_err <= r_err + 1'b1;
            if (!r_fe_vld) begin
              r_fe_vld <= 1'b1;
              r_fe_idx <= r_idx;
              r_fe_exp <= w_exp;
              r_fe_got <= q_obs;
            end
          end else begin
            r_match <= r_match + 1'b1;
          end
        end
      end
      // Registered so done rises on the final compare edge itself.
      r_done <= (w_next == S_DONE);
    end
  end

  assign busy          = w_busy;
  assign done          = r_done;
  assign pass          = r_done && (r_err == '0);
  assign match_count   = r_match;
  assign err_count     = r_err;
  assign first_err_vld = r_fe_vld;
  assign first_err_idx = r_fe_idx;
  assign first_err_exp = r_fe_exp;
  assign first_err_got = r_fe_got;

endmodule
`default_nettype wire

// File: tb/tb_reg8_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg8_resp_checker
// Purpose  : Directed testbench for reg8_resp_checker. Two checkers share the
//            stimulus: one watches an ideal register (LATENCY=1, with optional
//            single-bit corruption on chosen samples), the other watches a
//            register followed by an extra flop (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg8_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] d_obs;
  logic [7:0] q_reg;
  logic [7:0] q_a;
  logic [7:0] q_b;
  logic [7:0] q_obs1;
  logic [7:0] q_obs2;
  logic       flip;
  int         inj_mode;

  logic       busy1, done1, pass1, vld1;
  logic [8:0] match1, err1, idx1;
  logic [7:0] exp1, got1;
  logic       busy2, done2, pass2, vld2;
  logic [8:0] match2, err2, idx2;
  logic [7:0] exp2, got2;

  int         errors = 0;
  int         checks = 0;
  int         done1_at, done2_at;
  logic [8:0] s_match, s_err;
  logic       s_vld, s_busy, busy2_256;

  always #5 clk = ~clk;

  // Register under observation: plain flop for checker 1, two flops for checker 2.
  always @(posedge clk) begin
    q_reg <= d_obs;
    q_a   <= d_obs;
    q_b   <= q_a;
  end

  // Corrupt bit 0 while the register presents sample 4 (mode 1), or samples
  // 4, 10 and 20 (mode 2).
  assign flip   = ((inj_mode >= 1) && (q_reg == 8'd4)) ||
                  ((inj_mode == 2) && ((q_reg == 8'd10) || (q_reg == 8'd20)));
  assign q_obs1 = q_reg | {7'b0, flip};
  assign q_obs2 = q_b;

  reg8_resp_checker #(.WIDTH(8), .LATENCY(1), .NUM_SAMPLES(256)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .d_obs(d_obs), .q_obs(q_obs1),
    .busy(busy1), .done(done1), .pass(pass1), .match_count(match1),
    .err_count(err1), .first_err_vld(vld1), .first_err_idx(idx1),
    .first_err_exp(exp1), .first_err_got(got1)
  );

  reg8_resp_checker #(.WIDTH(8), .LATENCY(2), .NUM_SAMPLES(256)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .d_obs(d_obs), .q_obs(q_obs2),
    .busy(busy2), .done(done2), .pass(pass2), .match_count(match2),
    .err_count(err2), .first_err_vld(vld2), .first_err_idx(idx2),
    .first_err_exp(exp2), .first_err_got(got2)
  );

  // Start at edge E0 with d_obs = 0, then d_obs = e at edge E0+e. Observes
  // #1 after each edge for nedges edges past E0. restart_at / rst_at pulse
  // start / drop rst_n for the single edge E0+n (use -1 for none).
  task automatic run_ramp(input int restart_at, input int rst_at, input int nedges);
    d_obs    = 8'd0;
    start    = 1'b1;
    rst_n    = 1'b1;
    done1_at = -1;
    done2_at = -1;
    for (int e = 0; e <= nedges; e++) begin
      @(posedge clk);
      #1;
      if (done1 && done1_at < 0) done1_at = e;
      if (done2 && done2_at < 0) done2_at = e;
      if (e == 0) begin
        s_match = match1;
        s_err   = err1;
        s_vld   = vld1;
        s_busy  = busy1;
      end
      if (e == 256) busy2_256 = busy2;
      start = (e + 1 == restart_at);
      rst_n = !(e + 1 == rst_at);
      d_obs = 8'(e + 1);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    // start held high during reset: reset must win.
    rst_n = 1'b0;
    start = 1'b1;
    d_obs = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b want 0", done1); end
    checks++; if (pass1 !== 1'b0)   begin errors++; $display("FAIL rst_pass: got %b want 0", pass1); end
    checks++; if (match1 !== 9'd0)  begin errors++; $display("FAIL rst_match: got %0d want 0", match1); end
    checks++; if (err1 !== 9'd0)    begin errors++; $display("FAIL rst_err: got %0d want 0", err1); end
    checks++; if (vld1 !== 1'b0)    begin errors++; $display("FAIL rst_vld: got %b want 0", vld1); end
    checks++; if (idx1 !== 9'd0)    begin errors++; $display("FAIL rst_idx: got %0d want 0", idx1); end
    checks++; if (exp1 !== 8'd0)    begin errors++; $display("FAIL rst_exp: got %0h want 0", exp1); end
    checks++; if (got1 !== 8'd0)    begin errors++; $display("FAIL rst_got: got %0h want 0", got1); end
    checks++; if (busy2 !== 1'b0)   begin errors++; $display("FAIL rst_busy2: got %b want 0", busy2); end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL rst_idle_hold: got busy=%b want 0", busy1); end
  endtask

  task automatic test_ideal;
    inj_mode = 0;
    run_ramp(-1, -1, 258);
    checks++; if (s_busy !== 1'b1)  begin errors++; $display("FAIL ideal_busy_e0: got %b want 1", s_busy); end
    checks++; if (done1_at != 256)  begin errors++; $display("FAIL ideal_done_edge: got %0d want 256", done1_at); end
    checks++; if (match1 !== 9'd256) begin errors++; $display("FAIL ideal_match: got %0d want 256", match1); end
    checks++; if (err1 !== 9'd0)    begin errors++; $display("FAIL ideal_err: got %0d want 0", err1); end
    checks++; if (pass1 !== 1'b1)   begin errors++; $display("FAIL ideal_pass: got %b want 1", pass1); end
    checks++; if (vld1 !== 1'b0)    begin errors++; $display("FAIL ideal_vld: got %b want 0", vld1); end
    checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL ideal_busy_end: got %b want 0", busy1); end
  endtask

  task automatic test_single_error;
    inj_mode = 1;
    run_ramp(-1, -1, 258);
    inj_mode = 0;
    checks++; if (done1_at != 256)  begin errors++; $display("FAIL serr_done_edge: got %0d want 256", done1_at); end
    checks++; if (err1 !== 9'd1)    begin errors++; $display("FAIL serr_err: got %0d want 1", err1); end
    checks++; if (match1 !== 9'd255) begin errors++; $display("FAIL serr_match: got %0d want 255", match1); end
    checks++; if (pass1 !== 1'b0)   begin errors++; $display("FAIL serr_pass: got %b want 0", pass1); end
    checks++; if (vld1 !== 1'b1)    begin errors++; $display("FAIL serr_vld: got %b want 1", vld1); end
    checks++; if (idx1 !== 9'd4)    begin errors++; $display("FAIL serr_idx: got %0d want 4", idx1); end
    checks++; if (exp1 !== 8'h04)   begin errors++; $display("FAIL serr_exp: got %0h want 04", exp1); end
    checks++; if (got1 !== 8'h05)   begin errors++; $display("FAIL serr_got: got %0h want 05", got1); end
  endtask

  task automatic test_restart_ignored;
    run_ramp(50, -1, 258);
    checks++; if (done1_at != 256)  begin errors++; $display("FAIL rstrt_done_edge: got %0d want 256", done1_at); end
    checks++; if (match1 !== 9'd256) begin errors++; $display("FAIL rstrt_match: got %0d want 256", match1); end
    checks++; if (err1 !== 9'd0)    begin errors++; $display("FAIL rstrt_err: got %0d want 0", err1); end
    checks++; if (pass1 !== 1'b1)   begin errors++; $display("FAIL rstrt_pass: got %b want 1", pass1); end
  endtask

  task automatic test_reset_midrun;
    run_ramp(-1, 100, 100);
    checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL mrst_busy: got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0)   begin errors++; $display("FAIL mrst_done: got %b want 0", done1); end
    checks++; if (match1 !== 9'd0)  begin errors++; $display("FAIL mrst_match: got %0d want 0", match1); end
    checks++; if (err1 !== 9'd0)    begin errors++; $display("FAIL mrst_err: got %0d want 0", err1); end
    checks++; if (busy2 !== 1'b0)   begin errors++; $display("FAIL mrst_busy2: got %b want 0", busy2); end
    run_ramp(-1, -1, 258);
    checks++; if (done1_at != 256)  begin errors++; $display("FAIL mrst_rerun_done: got %0d want 256", done1_at); end
    checks++; if (pass1 !== 1'b1)   begin errors++; $display("FAIL mrst_rerun_pass: got %b want 1", pass1); end
    checks++; if (match1 !== 9'd256) begin errors++; $display("FAIL mrst_rerun_match: got %0d want 256", match1); end
  endtask

  task automatic test_latency2;
    run_ramp(-1, -1, 258);
    checks++; if (busy2_256 !== 1'b1) begin errors++; $display("FAIL lat2_busy_e256: got %b want 1", busy2_256); end
    checks++; if (done2_at != 257)  begin errors++; $display("FAIL lat2_done_edge: got %0d want 257", done2_at); end
    checks++; if (match2 !== 9'd256) begin errors++; $display("FAIL lat2_match: got %0d want 256", match2); end
    checks++; if (err2 !== 9'd0)    begin errors++; $display("FAIL lat2_err: got %0d want 0", err2); end
    checks++; if (pass2 !== 1'b1)   begin errors++; $display("FAIL lat2_pass: got %b want 1", pass2); end
    checks++; if (busy2 !== 1'b0)   begin errors++; $display("FAIL lat2_busy_end: got %b want 0", busy2); end
  endtask

  task automatic test_back_to_back;
    inj_mode = 2;
    run_ramp(-1, -1, 258);
    inj_mode = 0;
    checks++; if (err1 !== 9'd3)    begin errors++; $display("FAIL b2b_err3: got %0d want 3", err1); end
    checks++; if (match1 !== 9'd253) begin errors++; $display("FAIL b2b_match253: got %0d want 253", match1); end
    checks++; if (idx1 !== 9'd4)    begin errors++; $display("FAIL b2b_idx: got %0d want 4", idx1); end
    checks++; if (got1 !== 8'h05)   begin errors++; $display("FAIL b2b_got: got %0h want 05", got1); end
    run_ramp(-1, -1, 258);
    checks++; if (s_err !== 9'd0)   begin errors++; $display("FAIL b2b_e0_err: got %0d want 0", s_err); end
    checks++; if (s_match !== 9'd0) begin errors++; $display("FAIL b2b_e0_match: got %0d want 0", s_match); end
    checks++; if (s_vld !== 1'b0)   begin errors++; $display("FAIL b2b_e0_vld: got %b want 0", s_vld); end
    checks++; if (s_busy !== 1'b1)  begin errors++; $display("FAIL b2b_e0_busy: got %b want 1", s_busy); end
    checks++; if (err1 !== 9'd0)    begin errors++; $display("FAIL b2b_final_err: got %0d want 0", err1); end
    checks++; if (match1 !== 9'd256) begin errors++; $display("FAIL b2b_final_match: got %0d want 256", match1); end
    checks++; if (pass1 !== 1'b1)   begin errors++; $display("FAIL b2b_final_pass: got %b want 1", pass1); end
  endtask

  initial begin
    inj_mode = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    d_obs    = 8'd0;
    test_reset();
    test_ideal();
    test_single_error();
    test_restart_ignored();
    test_reset_midrun();
    test_latency2();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
